// File: rtl/idt_cfg_rx.sv
// idt_cfg_rx: serial configuration receiver for the IDT clock synthesizer
// programming bus. Synchronizes sclk/data/strobe, shifts in 24-bit frames
// MSB first, and on each strobe rise either latches and decodes the word,
// flags a malformed frame, or ignores the strobe when no bits were seen.
module idt_cfg_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        osc_clk,
  input  logic        osc_reset,
  input  logic        idt_sclk,
  input  logic        idt_data,
  input  logic        idt_strobe,
  output logic [23:0] cfg_word,
  output logic [6:0]  cfg_r,
  output logic [8:0]  cfg_v,
  output logic [2:0]  cfg_s,
  output logic [1:0]  cfg_f,
  output logic        cfg_ttl,
  output logic [1:0]  cfg_c,
  output logic [9:0]  cfg_vdw,
  output logic [7:0]  cfg_rdw,
  output logic [3:0]  cfg_odiv,
  output logic        cfg_valid,
  output logic        cfg_err,
  output logic        cfg_loaded,
  output logic [7:0]  cfg_load_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Output divide ratio selected by the s field.
  function automatic logic [3:0] odiv_lut(input logic [2:0] s);
    logic [3:0] d;
    case (s)
      3'd0:    d = 4'd10;
      3'd1:    d = 4'd2;
      3'd2:    d = 4'd8;
      3'd3:    d = 4'd4;
      3'd4:    d = 4'd5;
      3'd5:    d = 4'd7;
      3'd6:    d = 4'd3;
      3'd7:    d = 4'd6;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // Synchronizer chains; the last stage is the one the logic uses.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] strobe_sync_q;
  logic                   sclk_dly_q;
  logic                   strobe_dly_q;
  logic                   strobe_rise_q;

  logic sclk_rise_s;
  logic strobe_rise_s;
  logic data_s;

  state_t      state_q,     state_d;
  logic [4:0]  bit_cnt_q,   bit_cnt_d;
  logic [23:0] shreg_q,     shreg_d;
  logic [23:0] word_q,      word_d;
  logic [9:0]  vdw_q,       vdw_d;
  logic [7:0]  rdw_q,       rdw_d;
  logic [3:0]  odiv_q,      odiv_d;
  logic        valid_q,     valid_d;
  logic        err_q,       err_d;
  logic        loaded_q,    loaded_d;
  logic [7:0]  load_cnt_q,  load_cnt_d;

  assign sclk_rise_s   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
  assign strobe_rise_s = strobe_sync_q[SYNC_STAGES-1] & ~strobe_dly_q;
  assign data_s        = data_sync_q[SYNC_STAGES-1];

  // Input synchronizers, edge-detect delay copies and the registered strobe edge.
  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      sclk_sync_q   <= '0;
      data_sync_q   <= '0;
      strobe_sync_q <= '0;
      sclk_dly_q    <= 1'b0;
      strobe_dly_q  <= 1'b0;
      strobe_rise_q <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], idt_sclk};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], idt_data};
      strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], idt_strobe};
      sclk_dly_q    <= sclk_sync_q[SYNC_STAGES-1];
      strobe_dly_q  <= strobe_sync_q[SYNC_STAGES-1];
      strobe_rise_q <= strobe_rise_s;
    end
  end

  // Next-state logic: shift first, then evaluate any strobe against the
  // post-shift count so a coincident final bit is included in the frame.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    word_d     = word_q;
    vdw_d      = vdw_q;
    rdw_d      = rdw_q;
    odiv_d     = odiv_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    loaded_d   = loaded_q;
    load_cnt_d = load_cnt_q;

    if (sclk_rise_s) begin
      shreg_d   = {shreg_q[22:0], data_s};
      bit_cnt_d = (bit_cnt_q == 5'd31) ? 5'd31 : (bit_cnt_q + 5'd1);
      case (state_q)
        ST_IDLE:  state_d = ST_SHIFT;
        ST_SHIFT: state_d = ST_SHIFT;
        default:  state_d = ST_SHIFT;
      endcase
    end else begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
    end

    if (strobe_rise_q) begin
      case (bit_cnt_d)
        5'd0: begin
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
        5'd24: begin
          word_d     = shreg_d;
          vdw_d      = {1'b0, shreg_d[15:7]} + 10'd8;
          rdw_d      = {1'b0, shreg_d[6:0]} + 8'd2;
          odiv_d     = odiv_lut(shreg_d[18:16]);
          valid_d    = 1'b1;
          loaded_d   = 1'b1;
          load_cnt_d = load_cnt_q + 8'd1;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
      bit_cnt_d = 5'd0;
      state_d   = ST_IDLE;
    end else begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Receiver state, shift register and registered outputs.
  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 5'd0;
      shreg_q    <= 24'd0;
      word_q     <= 24'd0;
      vdw_q      <= 10'd0;
      rdw_q      <= 8'd0;
      odiv_q     <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      loaded_q   <= 1'b0;
      load_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      word_q     <= word_d;
      vdw_q      <= vdw_d;
      rdw_q      <= rdw_d;
      odiv_q     <= odiv_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      loaded_q   <= loaded_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign cfg_word     = word_q;
  assign cfg_r        = word_q[6:0];
  assign cfg_v        = word_q[15:7];
  assign cfg_s        = word_q[18:16];
  assign cfg_f        = word_q[20:19];
  assign cfg_ttl      = word_q[21];
  assign cfg_c        = word_q[23:22];
  assign cfg_vdw      = vdw_q;
  assign cfg_rdw      = rdw_q;
  assign cfg_odiv     = odiv_q;
  assign cfg_valid    = valid_q;
  assign cfg_err      = err_q;
  assign cfg_loaded   = loaded_q;
  assign cfg_load_cnt = load_cnt_q;

endmodule

// File: tb/tb_idt_cfg_rx.sv
// Scoreboard bench for idt_cfg_rx: stimulus pushes the expected response of
// every strobe, a monitor pops and compares whenever a pulse appears.
module tb_idt_cfg_rx;

  logic        osc_clk = 1'b0;
  logic        osc_reset = 1'b1;
  logic        idt_sclk = 1'b0;
  logic        idt_data = 1'b0;
  logic        idt_strobe = 1'b0;
  logic [23:0] cfg_word;
  logic [6:0]  cfg_r;
  logic [8:0]  cfg_v;
  logic [2:0]  cfg_s;
  logic [1:0]  cfg_f;
  logic        cfg_ttl;
  logic [1:0]  cfg_c;
  logic [9:0]  cfg_vdw;
  logic [7:0]  cfg_rdw;
  logic [3:0]  cfg_odiv;
  logic        cfg_valid;
  logic        cfg_err;
  logic        cfg_loaded;
  logic [7:0]  cfg_load_cnt;

  idt_cfg_rx #(.SYNC_STAGES(2)) dut (
    .osc_clk(osc_clk), .osc_reset(osc_reset),
    .idt_sclk(idt_sclk), .idt_data(idt_data), .idt_strobe(idt_strobe),
    .cfg_word(cfg_word), .cfg_r(cfg_r), .cfg_v(cfg_v), .cfg_s(cfg_s),
    .cfg_f(cfg_f), .cfg_ttl(cfg_ttl), .cfg_c(cfg_c),
    .cfg_vdw(cfg_vdw), .cfg_rdw(cfg_rdw), .cfg_odiv(cfg_odiv),
    .cfg_valid(cfg_valid), .cfg_err(cfg_err),
    .cfg_loaded(cfg_loaded), .cfg_load_cnt(cfg_load_cnt)
  );

  always #5 osc_clk = ~osc_clk;

  typedef struct {
    logic        is_err;
    logic [23:0] word;
    logic [9:0]  vdw;
    logic [7:0]  rdw;
    logic [3:0]  odiv;
    logic        loaded;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state (what the outputs should currently hold).
  logic [23:0] m_word;
  logic [9:0]  m_vdw;
  logic [7:0]  m_rdw;
  logic [3:0]  m_odiv;
  logic        m_loaded;
  logic [7:0]  m_cnt;
  logic [3:0]  odiv_tab [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 24'd0; m_vdw = 10'd0; m_rdw = 8'd0; m_odiv = 4'd0;
    m_loaded = 1'b0; m_cnt = 8'd0;
  endtask

  // Push a valid load with hand-supplied derived values.
  task automatic expect_load(input logic [23:0] w, input logic [9:0] vdw,
                             input logic [7:0] rdw, input logic [3:0] odiv);
    exp_t e;
    m_word = w; m_vdw = vdw; m_rdw = rdw; m_odiv = odiv;
    m_loaded = 1'b1; m_cnt = m_cnt + 8'd1;
    e.is_err = 1'b0; e.word = m_word; e.vdw = m_vdw; e.rdw = m_rdw;
    e.odiv = m_odiv; e.loaded = m_loaded; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.word = m_word; e.vdw = m_vdw; e.rdw = m_rdw;
    e.odiv = m_odiv; e.loaded = m_loaded; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge osc_clk) begin
    if (cfg_valid === 1'b1 || cfg_err === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse got valid=%0b err=%0b exp=none", cfg_valid, cfg_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid", {31'd0, cfg_valid}, {31'd0, ~e.is_err});
        chk("err", {31'd0, cfg_err}, {31'd0, e.is_err});
        chk("word", {8'd0, cfg_word}, {8'd0, e.word});
        chk("r", {25'd0, cfg_r}, {25'd0, e.word[6:0]});
        chk("v", {23'd0, cfg_v}, {23'd0, e.word[15:7]});
        chk("s", {29'd0, cfg_s}, {29'd0, e.word[18:16]});
        chk("f", {30'd0, cfg_f}, {30'd0, e.word[20:19]});
        chk("ttl", {31'd0, cfg_ttl}, {31'd0, e.word[21]});
        chk("c", {30'd0, cfg_c}, {30'd0, e.word[23:22]});
        chk("vdw", {22'd0, cfg_vdw}, {22'd0, e.vdw});
        chk("rdw", {24'd0, cfg_rdw}, {24'd0, e.rdw});
        chk("odiv", {28'd0, cfg_odiv}, {28'd0, e.odiv});
        chk("loaded", {31'd0, cfg_loaded}, {31'd0, e.loaded});
        chk("load_cnt", {24'd0, cfg_load_cnt}, {24'd0, e.cnt});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  // Shift n bits, MSB (bit n-1) first; optionally raise strobe with the last sclk rise.
  task automatic send_bits(input logic [31:0] bits, input int n, input bit coincide);
    for (int i = n - 1; i >= 0; i--) begin
      idt_data = bits[i];
      idt_sclk = 1'b0;
      cyc(2);
      idt_sclk = 1'b1;
      if (coincide && i == 0) idt_strobe = 1'b1;
      cyc(2);
    end
    idt_sclk = 1'b0;
    cyc(2);
  endtask

  task automatic strobe();
    idt_strobe = 1'b1;
    cyc(3);
    idt_strobe = 1'b0;
    cyc(8);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      cyc(1);
      k++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_word"}, {8'd0, cfg_word}, {8'd0, m_word});
    chk({tag, "_vdw"}, {22'd0, cfg_vdw}, {22'd0, m_vdw});
    chk({tag, "_rdw"}, {24'd0, cfg_rdw}, {24'd0, m_rdw});
    chk({tag, "_odiv"}, {28'd0, cfg_odiv}, {28'd0, m_odiv});
    chk({tag, "_loaded"}, {31'd0, cfg_loaded}, {31'd0, m_loaded});
    chk({tag, "_cnt"}, {24'd0, cfg_load_cnt}, {24'd0, m_cnt});
    chk({tag, "_pulse"}, {30'd0, cfg_valid, cfg_err}, 32'd0);
  endtask

  initial begin
    logic [23:0] w;
    odiv_tab = '{4'd10, 4'd2, 4'd8, 4'd4, 4'd5, 4'd7, 4'd3, 4'd6};
    model_reset();
    cyc(4);
    check_hold("reset");
    osc_reset = 1'b0;
    cyc(3);

    // Full frame 0x31280A.
    send_bits({8'd0, 24'h31280A}, 24, 1'b0);
    expect_load(24'h31280A, 10'd88, 8'd12, 4'd2);
    strobe();
    drain();

    // Two strobes with no data: nothing happens.
    strobe();
    strobe();
    check_hold("idle_strobe");

    // 23-bit frame rejected, then all-zero frame loads.
    send_bits({8'd0, 24'hABCDEF}, 23, 1'b0);
    expect_err();
    strobe();
    drain();
    check_hold("short");
    send_bits(32'd0, 24, 1'b0);
    expect_load(24'h000000, 10'd8, 8'd2, 4'd10);
    strobe();
    drain();

    // 26-bit frame rejected.
    send_bits(32'h3FF_FFFF, 26, 1'b0);
    expect_err();
    strobe();
    drain();
    check_hold("long");

    // Strobe coincident with the 24th sclk rise still loads.
    send_bits({8'd0, 24'h31280A}, 24, 1'b1);
    expect_load(24'h31280A, 10'd88, 8'd12, 4'd2);
    cyc(2);
    idt_strobe = 1'b0;
    cyc(8);
    drain();

    // Reset mid-frame discards everything.
    send_bits({8'd0, 24'h555555}, 12, 1'b0);
    osc_reset = 1'b1;
    cyc(3);
    osc_reset = 1'b0;
    model_reset();
    cyc(1);
    check_hold("midreset");
    send_bits({8'd0, 24'hC3FFFF}, 24, 1'b0);
    expect_load(24'hC3FFFF, 10'd519, 8'd129, 4'd4);
    strobe();
    drain();

    // s sweep with hand-tabulated divide values.
    for (int k = 0; k < 8; k++) begin
      w = 24'd0;
      w[18:16] = k[2:0];
      send_bits({8'd0, w}, 24, 1'b0);
      expect_load(w, 10'd8, 8'd2, odiv_tab[k]);
      strobe();
      drain();
    end

    // Fill to 256 loads so the counter wraps.
    while (m_cnt != 8'd0) begin
      w = 24'($urandom);
      send_bits({8'd0, w}, 24, 1'b0);
      expect_load(w, {1'b0, w[15:7]} + 10'd8, {1'b0, w[6:0]} + 8'd2, odiv_tab[w[18:16]]);
      strobe();
      drain();
    end
    chk("wrap_cnt", {24'd0, cfg_load_cnt}, 32'd0);
    chk("wrap_loaded", {31'd0, cfg_loaded}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idt_cfg_rx.md
# idt_cfg_rx

Serial configuration receiver for the IDT clock synthesizer programming interface. It samples the three-wire sclk/data/strobe bus and shifts in 24-bit frames, MSB first. On strobe it validates the bit count, latches the word, and decodes the R/V/S/F/TTL/C fields plus derived divider values. It sits beside the clock-generator programming logic as an on-chip monitor and bench checker, so software and tests can read back the configuration actually sent to the synthesizer.

## Interface
- SYNC_STAGES, 2, synchronizer depth applied identically to sclk, data and strobe; legal values are 2 or more.

- osc_clk  in  1  sole clock.
- osc_reset  in  1  synchronous, active-high reset.
- idt_sclk  in  1  serial clock; data is sampled on its rising edge.
- idt_data  in  1  serial data; the first bit received is bit 23.
- idt_strobe  in  1  load strobe; its rising edge ends a frame.
- cfg_word  out  24  last valid word, laid out as {c[1:0], ttl, f[1:0], s[2:0], v[8:0], r[6:0]}.
- cfg_r  out  7  cfg_word[6:0].
- cfg_v  out  9  cfg_word[15:7].
- cfg_s  out  3  cfg_word[18:16].
- cfg_f  out  2  cfg_word[20:19].
- cfg_ttl  out  1  cfg_word[21].
- cfg_c  out  2  cfg_word[23:22].
- cfg_vdw  out  10  v+8.
- cfg_rdw  out  8  r+2.
- cfg_odiv  out  4  output divide decoded from s.
- cfg_valid  out  1  one-cycle pulse when a good frame is loaded.
- cfg_err  out  1  one-cycle pulse when a malformed frame is rejected.
- cfg_loaded  out  1  sticky; set by the first valid load.
- cfg_load_cnt  out  8  count of valid loads; wraps 255 to 0.

## Operation
- Each input passes through a SYNC_STAGES flop chain.
  - Edges are detected on the last stage against a one-cycle-delayed copy.
  - sclk and data use equal chain depth, so they stay aligned.
- Receiver states:
  - IDLE: bit_cnt = 0.
  - SHIFT: bit_cnt between 1 and 31.
- Synced sclk rise:
  - shreg <= {shreg[22:0], data_sync}.
  - bit_cnt increments and saturates at 31.
  - IDLE moves to SHIFT.
- Synced strobe rise, evaluated after any same-cycle sclk shift (the coincident bit is counted):
  - bit_cnt == 0: ignored. No pulse, outputs hold. This covers repeated or stuck strobes with no new data.
  - bit_cnt == 24: latch cfg_word <= shreg and all decoded fields.
    - Pulse cfg_valid.
    - Set cfg_loaded.
    - Increment cfg_load_cnt.
  - Any other value, including saturated counts from over-long frames: pulse cfg_err. All cfg_* data outputs hold.
  - In every case bit_cnt <= 0 and the state returns to IDLE.
- A strobe held high does not block shifting. Only its rising edge acts.
- Arithmetic:
  - cfg_vdw = zero-extended v + 8.
  - cfg_rdw = zero-extended r + 2.
  - Neither can overflow.
- cfg_odiv lookup for s = 0..7: 10, 2, 8, 4, 5, 7, 3, 6.
- cfg_vdw, cfg_rdw and cfg_odiv are registered and update in the same cycle as cfg_word.

## Timing
- Reset (synchronous, active-high, wins over everything):
  - All outputs go to 0, including cfg_odiv, cfg_vdw and cfg_rdw.
  - Synchronizers, shreg and bit_cnt are cleared.
  - A frame in progress is discarded.
- Edge-detect latency: a pin level first captured at posedge n is seen as an edge at posedge n+SYNC_STAGES.
- Load latency: cfg_valid or cfg_err is high in the cycle after posedge n+SYNC_STAGES+1, where n is the posedge that first captured strobe high.
  - Data outputs change on that same edge.
- Pulses last exactly one cycle.
- Back-to-back strobe rises need at least two cycles between them; each is evaluated independently.
- Minimum sclk high and low time: 1 osc_clk cycle each.
- data must be stable for 1 cycle on each side of the sclk rise, which the transmitter's half-rate sclk guarantees.

## Test plan
- Full frame 0x31280A (r=10, v=80, s=1, f=2, ttl=1, c=0), then strobe -> cfg_valid pulses once.
  - cfg_word=0x31280A, cfg_vdw=88, cfg_rdw=12, cfg_odiv=2.
  - cfg_loaded=1, cfg_load_cnt=1.
- After that load, two further strobe pulses with no sclk -> no cfg_valid or cfg_err; all outputs hold 0x31280A values.
- 23 bits then strobe -> cfg_err pulses once and cfg_word is unchanged. A following full frame 0x000000 loads normally (cfg_odiv=10, cfg_vdw=8, cfg_rdw=2).
- 26 bits then strobe -> cfg_err pulses once and cfg_load_cnt is unchanged. Also check the coincidence case: 24th sclk rise and strobe rise in the same synced cycle -> cfg_valid.
- Reset asserted after 12 bits -> all outputs 0 and bit_cnt 0. A fresh frame 0xC3FFFF then loads:
  - c=3, ttl=0, f=0, s=3, v=511, r=127.
  - cfg_vdw=519, cfg_rdw=129, cfg_odiv=4.
- Sweep s = 0..7 across eight frames -> cfg_odiv = 10, 2, 8, 4, 5, 7, 3, 6. Continue to 256 valid loads -> cfg_load_cnt wraps to 0 while cfg_loaded stays 1.
